// File: rtl/apx_operand_prep_pkg.sv
// Shared sizing for the approximate multiplier datapath (operand prep, shifter, multiplier top).
package apx_operand_prep_pkg;

  localparam int unsigned ApxWidth     = 16;
  localparam int unsigned ApxRounWidth = 0;
  localparam int unsigned ApxLog2Width = 4;
  localparam int unsigned ApxYWidth    = ApxWidth + ApxRounWidth;

endpackage

// File: rtl/leading_one_detector.sv
// Combinational priority encoder: K is the index of the most significant set bit of IN.
module leading_one_detector #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LOG2_WIDTH = 4
) (
  input  logic [WIDTH-1:0]      IN,
  output logic [LOG2_WIDTH-1:0] K,
  output logic                  found
);

  // Ascending scan: the last set bit seen wins, which is the most significant one.
  always_comb begin
    K     = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (IN[i]) begin
        K     = LOG2_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apx_operand_prep.sv
// Two-stage operand front-end: S1 takes magnitudes and signs, S2 adds leading-one index,
// product sign and zero flag for the downstream shifter.
module apx_operand_prep
  import apx_operand_prep_pkg::*;
#(
  parameter int unsigned WIDTH      = ApxWidth,
  parameter int unsigned ROUN_WIDTH = ApxRounWidth,
  parameter int unsigned LOG2_WIDTH = ApxLog2Width
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_x,
  input  logic [WIDTH+ROUN_WIDTH-1:0] in_y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_x,
  output logic [WIDTH+ROUN_WIDTH-1:0] out_y,
  output logic [LOG2_WIDTH-1:0]       out_k,
  output logic                        out_sign,
  output logic                        out_zero
);

  localparam int unsigned YW = WIDTH + ROUN_WIDTH;

  logic          s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q;
  logic [YW-1:0] s1_y_q;
  logic          s1_sx_q, s1_sy_q;

  logic          s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_x_q;
  logic [YW-1:0] s2_y_q;
  logic [LOG2_WIDTH-1:0] s2_k_q;
  logic          s2_sign_q, s2_zero_q;

  logic          s2_adv, s1_load, s2_load;
  logic [WIDTH-1:0] abs_x;
  logic [YW-1:0] abs_y;
  logic [LOG2_WIDTH-1:0] lod_k;
  logic          lod_found, s1_zero;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_adv;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s2_adv & s1_valid_q;

  // Unsigned magnitude: the most negative input maps to 2^(W-1) without saturation.
  assign abs_x = in_x[WIDTH-1] ? -in_x : in_x;
  assign abs_y = in_y[YW-1] ? -in_y : in_y;

  leading_one_detector #(
    .WIDTH      (WIDTH),
    .LOG2_WIDTH (LOG2_WIDTH)
  ) u_lod (
    .IN    (s1_x_q),
    .K     (lod_k),
    .found (lod_found)
  );

  assign s1_zero = ~lod_found | (s1_y_q == '0);

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_sx_q    <= 1'b0;
      s1_sy_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      s2_k_q     <= '0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        s1_x_q  <= abs_x;
        s1_y_q  <= abs_y;
        s1_sx_q <= in_x[WIDTH-1];
        s1_sy_q <= in_y[YW-1];
      end
      if (s2_load) begin
        s2_x_q    <= s1_x_q;
        s2_y_q    <= s1_y_q;
        s2_zero_q <= s1_zero;
        // A zero product carries no meaningful exponent or sign.
        s2_k_q    <= s1_zero ? '0 : lod_k;
        s2_sign_q <= ~s1_zero & (s1_sx_q ^ s1_sy_q);
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_x     = s2_x_q;
  assign out_y     = s2_y_q;
  assign out_k     = s2_k_q;
  assign out_sign  = s2_sign_q;
  assign out_zero  = s2_zero_q;

endmodule

// File: tb/tb_apx_operand_prep.sv
// Bench for apx_operand_prep: directed vectors, backpressure, reset and random traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_apx_operand_prep;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  k;
    logic        sign;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [3:0]  out_k;
  logic        out_sign;
  logic        out_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_pop   = 0;
  exp_t q[$];

  apx_operand_prep #(
    .WIDTH      (16),
    .ROUN_WIDTH (0),
    .LOG2_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_k     (out_k),
    .out_sign  (out_sign),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sign-magnitude via integer arithmetic, K as floor(log2 |X|).
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int xs, ys, mx, my, m, k;
    xs = $signed(x);
    ys = $signed(y);
    mx = (xs < 0) ? -xs : xs;
    my = (ys < 0) ? -ys : ys;
    k = 0;
    m = mx;
    while (m > 1) begin
      m = m / 2;
      k++;
    end
    e.x    = mx[15:0];
    e.y    = my[15:0];
    e.zero = (mx == 0) || (my == 0);
    e.k    = e.zero ? 4'd0 : k[3:0];
    e.sign = e.zero ? 1'b0 : ((xs < 0) != (ys < 0));
    return e;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock cycle; called just after a falling edge with inputs already driven.
  task automatic tick();
    exp_t e, held;
    logic acc, pop, hold;
    #1;
    acc  = in_valid && in_ready;
    pop  = out_valid && out_ready;
    hold = out_valid && !out_ready;
    held = {out_x, out_y, out_k, out_sign, out_zero};
    if (pop) begin
      n_pop++;
      if (q.size() == 0) begin
        check("unexpected_output", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        check("sb_bundle", 64'({out_x, out_y, out_k, out_sign, out_zero}), 64'(e));
      end
    end
    if (acc) begin
      n_acc++;
      q.push_back(model(in_x, in_y));
    end
    @(posedge clk);
    #1;
    if (hold) begin
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_data", 64'({out_x, out_y, out_k, out_sign, out_zero}), 64'(held));
    end
    @(negedge clk);
  endtask

  task automatic send_dir(input logic [15:0] x, input logic [15:0] y, input logic [15:0] ex,
                          input logic [15:0] ey, input logic [3:0] ek, input logic es,
                          input logic ez);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    tick();
    in_valid = 1'b0;
    check("dir_lat1_valid", 64'(out_valid), 64'(0));
    tick();
    check("dir_valid", 64'(out_valid), 64'(1));
    check("dir_bundle", 64'({out_x, out_y, out_k, out_sign, out_zero}),
          64'({ex, ey, ek, es, ez}));
  endtask

  initial begin
    int v, a0, p0;

    // Reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_data", 64'({out_x, out_y, out_k, out_sign, out_zero}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    send_dir(16'h0013, 16'h0005, 16'h0013, 16'h0005, 4'd4, 1'b0, 1'b0);
    send_dir(16'hFFED, 16'h0005, 16'h0013, 16'h0005, 4'd4, 1'b1, 1'b0);
    send_dir(16'hFFED, 16'hFFFB, 16'h0013, 16'h0005, 4'd4, 1'b0, 1'b0);
    send_dir(16'h8000, 16'h0001, 16'h8000, 16'h0001, 4'd15, 1'b1, 1'b0);
    send_dir(16'h0001, 16'h0001, 16'h0001, 16'h0001, 4'd0, 1'b0, 1'b0);
    send_dir(16'h0000, 16'h1234, 16'h0000, 16'h1234, 4'd0, 1'b0, 1'b1);
    send_dir(16'h0040, 16'h0000, 16'h0040, 16'h0000, 4'd0, 1'b0, 1'b1);
    send_dir(16'hFFFF, 16'h8000, 16'h0001, 16'h8000, 4'd0, 1'b0, 1'b0);
    tick();
    check("dir_drained", 64'(q.size()), 64'(0));

    // Backpressure: two accepts fill the pipe, then in_ready stays low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    v  = 1;
    a0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      in_x = 16'(v);
      in_y = 16'(v);
      if (i >= 2) check("bp_in_ready_low", 64'(in_ready), 64'(0));
      p0 = n_acc;
      tick();
      if (n_acc != p0) v++;
    end
    check("bp_accepts", 64'(n_acc - a0), 64'(2));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (v <= 4);
      in_x = 16'(v);
      in_y = 16'(v);
      check("bp_drain_valid", 64'(out_valid), 64'(1));
      check("bp_drain_x", 64'(out_x), 64'(i + 1));
      p0 = n_acc;
      tick();
      if (n_acc != p0) v++;
    end
    in_valid = 1'b0;
    check("bp_drained", 64'(q.size()), 64'(0));

    // Full throughput with out_ready held high
    p0 = n_pop;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_x = pick();
      in_y = pick();
      check("tp_in_ready", 64'(in_ready), 64'(1));
      tick();
    end
    check("tp_pops", 64'(n_pop - p0), 64'(8));
    in_valid = 1'b0;
    tick();
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_x = pick();
      in_y = pick();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6 && q.size() != 0; i++) tick();
    check("rand_drained", 64'(q.size()), 64'(0));
    check("rand_idle_valid", 64'(out_valid), 64'(0));

    // Asynchronous reset with two bundles in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x = 16'h1111;
    in_y = 16'hF000;
    tick();
    in_x = 16'h2222;
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    check("pre_rst_in_ready", 64'(in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_data", 64'({out_x, out_y, out_k, out_sign, out_zero}), 64'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_dir(16'hFF00, 16'h0003, 16'h0100, 16'h0003, 4'd8, 1'b1, 1'b0);
    tick();
    check("post_rst_idle", 64'(out_valid), 64'(0));
    check("post_rst_queue", 64'(q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
